// File: rtl/idex_pipe_stage.sv
// idex_pipe_stage: elastic ID/EX register with one-entry skid buffer, flush and saturating stall counter
module idex_pipe_stage #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int ALU_OP_W   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic [ALU_OP_W-1:0]   in_alu_ctrl,
    input  logic [DATA_W-1:0]     in_data1,
    input  logic [DATA_W-1:0]     in_data2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [REG_ADDR_W-1:0] in_rs,
    input  logic                  in_output_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_reg_write,
    output logic [ALU_OP_W-1:0]   out_alu_ctrl,
    output logic [DATA_W-1:0]     out_data1,
    output logic [DATA_W-1:0]     out_data2,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [REG_ADDR_W-1:0] out_rs,
    output logic                  out_output_sel,
    output logic [CNT_W-1:0]      stall_count
);
    localparam int PW = 2 + ALU_OP_W + 2 * DATA_W + 2 * REG_ADDR_W;
    logic          r_main_valid;
    logic          r_skid_valid;
    logic [PW-1:0] r_main_pl;
    logic [PW-1:0] r_skid_pl;
    logic [CNT_W-1:0] r_stall;
    logic [PW-1:0] w_in_pl;
    logic          w_accept;
    logic          w_load_main;
    logic          w_load_skid;
    logic          w_main_valid_nxt;
    logic          w_skid_valid_nxt;
    assign w_in_pl = {in_reg_write, in_alu_ctrl, in_data1, in_data2, in_rd, in_rs, in_output_sel};
    assign {out_reg_write, out_alu_ctrl, out_data1, out_data2, out_rd, out_rs, out_output_sel} = r_main_pl;
    assign out_valid   = r_main_valid;
    assign in_ready    = !r_skid_valid;
    assign stall_count = r_stall;
    assign w_accept         = in_valid & !r_skid_valid;
    assign w_load_main      = r_skid_valid ? out_ready : w_accept & (!r_main_valid | out_ready);
    assign w_load_skid      = w_accept & r_main_valid & !out_ready;
    assign w_main_valid_nxt = r_skid_valid | w_accept | (r_main_valid & !out_ready);
    assign w_skid_valid_nxt = r_skid_valid ? !out_ready : w_load_skid;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_pl    <= '0;
            r_skid_pl    <= '0;
        end else if (flush) begin
            r_main_valid  <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_main_pl[PW-1] <= 1'b0;
            r_main_pl[0]    <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_load_main)
                r_main_pl <= r_skid_valid ? r_skid_pl : w_in_pl;
            else if (!w_main_valid_nxt)
                r_main_pl[PW-1] <= 1'b0;
            if (w_load_skid)
                r_skid_pl <= w_in_pl;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall <= '0;
        else if (r_main_valid & !out_ready & ~&r_stall)
            r_stall <= r_stall + CNT_W'(1);
    end
endmodule

// File: tb/tb_idex_pipe_stage.sv
// tb_idex_pipe_stage: directed checks of handshake, skid, flush, reset and saturation
module tb_idex_pipe_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       flush, in_valid, in_ready, in_reg_write, in_output_sel;
    logic [1:0] in_alu_ctrl;
    logic [7:0] in_data1, in_data2;
    logic [2:0] in_rd, in_rs;
    logic       out_valid, out_ready, out_reg_write, out_output_sel;
    logic [1:0] out_alu_ctrl;
    logic [7:0] out_data1, out_data2;
    logic [2:0] out_rd, out_rs;
    logic [15:0] stall_count;

    logic        w_flush, w_in_valid, w_in_ready, w_in_reg_write, w_in_output_sel;
    logic [1:0]  w_in_alu_ctrl;
    logic [15:0] w_in_data1, w_in_data2;
    logic [4:0]  w_in_rd, w_in_rs;
    logic        w_out_valid, w_out_ready, w_out_reg_write, w_out_output_sel;
    logic [1:0]  w_out_alu_ctrl;
    logic [15:0] w_out_data1, w_out_data2;
    logic [4:0]  w_out_rd, w_out_rs;
    logic [3:0]  w_stall_count;

    idex_pipe_stage u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg_write(in_reg_write),
        .in_alu_ctrl(in_alu_ctrl), .in_data1(in_data1), .in_data2(in_data2),
        .in_rd(in_rd), .in_rs(in_rs), .in_output_sel(in_output_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_reg_write(out_reg_write),
        .out_alu_ctrl(out_alu_ctrl), .out_data1(out_data1), .out_data2(out_data2),
        .out_rd(out_rd), .out_rs(out_rs), .out_output_sel(out_output_sel),
        .stall_count(stall_count)
    );

    idex_pipe_stage #(.DATA_W(16), .REG_ADDR_W(5), .ALU_OP_W(2), .CNT_W(4)) u_wide (
        .clk(clk), .reset(reset), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_reg_write(w_in_reg_write),
        .in_alu_ctrl(w_in_alu_ctrl), .in_data1(w_in_data1), .in_data2(w_in_data2),
        .in_rd(w_in_rd), .in_rs(w_in_rs), .in_output_sel(w_in_output_sel),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_reg_write(w_out_reg_write),
        .out_alu_ctrl(w_out_alu_ctrl), .out_data1(w_out_data1), .out_data2(w_out_data2),
        .out_rd(w_out_rd), .out_rs(w_out_rs), .out_output_sel(w_out_output_sel),
        .stall_count(w_stall_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {flush, in_valid, in_reg_write, in_output_sel, in_alu_ctrl} = '0;
        {in_data1, in_data2, in_rd, in_rs, out_ready} = '0;
        {w_flush, w_in_valid, w_in_reg_write, w_in_output_sel, w_in_alu_ctrl} = '0;
        {w_in_data1, w_in_data2, w_in_rd, w_in_rs, w_out_ready} = '0;
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_stall", 32'(stall_count), 32'd0);
        check("rst_rw", 32'(out_reg_write), 32'd0);
        #9;
        reset = 1'b1;
        in_valid = 1'b1;
        in_data1 = 8'h5A;
        step;
        check("load_valid", 32'(out_valid), 32'd1);
        check("load_d1", 32'(out_data1), 32'h5A);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_d1", 32'(out_data1), 32'h00);
        check("async_ready", 32'(in_ready), 32'd1);
        #1 reset = 1'b1;

        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_rd = 3'(i);
            in_data1 = 8'(8'h11 * i);
            step;
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_rd", 32'(out_rd), 32'(i));
            check("stream_d1", 32'(out_data1), 32'(8'h11 * i));
            check("stream_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step;
        check("stream_empty", 32'(out_valid), 32'd0);
        check("stream_stall", 32'(stall_count), 32'd0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_reg_write = 1'b1;
        in_data1 = 8'hA1;
        in_rd = 3'd5;
        step;
        check("bp_a_d1", 32'(out_data1), 32'hA1);
        check("bp_a_ready", 32'(in_ready), 32'd1);
        in_data1 = 8'hB2;
        in_rd = 3'd6;
        step;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_full_d1", 32'(out_data1), 32'hA1);
        check("bp_stall1", 32'(stall_count), 32'd1);
        in_valid = 1'b0;
        step;
        check("bp_hold_d1", 32'(out_data1), 32'hA1);
        check("bp_stall2", 32'(stall_count), 32'd2);
        out_ready = 1'b1;
        step;
        check("bp_b_d1", 32'(out_data1), 32'hB2);
        check("bp_b_rd", 32'(out_rd), 32'd6);
        check("bp_b_valid", 32'(out_valid), 32'd1);
        check("bp_b_ready", 32'(in_ready), 32'd1);
        check("bp_stall_hold", 32'(stall_count), 32'd2);
        step;
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_drained_rw", 32'(out_reg_write), 32'd0);

        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data1 = 8'hA1;
        in_rd = 3'd5;
        step;
        in_data1 = 8'hB2;
        in_rd = 3'd6;
        step;
        check("fl_full", 32'(in_ready), 32'd0);
        in_data1 = 8'hC3;
        in_rd = 3'd7;
        flush = 1'b1;
        step;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_rw", 32'(out_reg_write), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        check("fl_hold_d1", 32'(out_data1), 32'hA1);
        check("fl_stall", 32'(stall_count), 32'd4);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step;
        check("fl_no_c_valid", 32'(out_valid), 32'd0);
        check("fl_no_c_rd", 32'(out_rd), 32'd5);

        w_in_valid = 1'b1;
        w_in_data2 = 16'hBEEF;
        w_in_rd = 5'd31;
        step;
        check("wide_valid", 32'(w_out_valid), 32'd1);
        check("wide_d2", 32'(w_out_data2), 32'hBEEF);
        check("wide_rd", 32'(w_out_rd), 32'd31);
        check("wide_stall0", 32'(w_stall_count), 32'd0);
        w_in_valid = 1'b0;
        for (int i = 0; i < 14; i++) step;
        check("sat_14", 32'(w_stall_count), 32'd14);
        step;
        check("sat_15", 32'(w_stall_count), 32'd15);
        for (int i = 0; i < 5; i++) step;
        check("sat_hold", 32'(w_stall_count), 32'd15);
        check("sat_valid", 32'(w_out_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/idex_pipe_stage.md
Name: idex_pipe_stage

Overview:
- Parametrised ID/EX pipeline stage for the custom 4-stage core.
- Sits between decode/register-read and execute.
- Generalises the plain ID/EX latch with:
  - valid/ready elastic handshake,
  - a one-entry skid buffer so upstream ready is fully registered,
  - synchronous flush for bubble insertion,
  - a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 8, width of operand fields data1/data2.
- REG_ADDR_W, 3, width of register specifiers rd/rs.
- ALU_OP_W, 2, width of ALU control field.
- CNT_W, 16, width of stall counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  decode presents a valid instruction.
- in_ready  output  1  stage can accept; registered, depends only on skid occupancy.
- in_reg_write  input  1  writeback enable.
- in_alu_ctrl  input  ALU_OP_W  ALU operation.
- in_data1  input  DATA_W  operand 1 from register file.
- in_data2  input  DATA_W  operand 2 / immediate.
- in_rd  input  REG_ADDR_W  destination register.
- in_rs  input  REG_ADDR_W  source register (for forwarding compare).
- in_output_sel  input  1  result/output select.
- out_valid  output  1  execute-side entry valid.
- out_ready  input  1  execute can consume.
- out_reg_write  output  1
- out_alu_ctrl  output  ALU_OP_W
- out_data1  output  DATA_W
- out_data2  output  DATA_W
- out_rd  output  REG_ADDR_W
- out_rs  output  REG_ADDR_W
- out_output_sel  output  1
- stall_count  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - all out_* payload cleared to 0; out_valid=0;
  - skid entry invalid and payload cleared to 0;
  - in_ready=1; stall_count=0.
- Storage: main register (drives out_*) plus one skid register; state = {main_valid, skid_valid}.
- Reachable states: EMPTY (0,0), ONE (1,0), FULL (1,1). The state (0,1) is illegal and never reachable.
- in_ready = !skid_valid, as a registered value. It must not depend combinationally on out_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Transitions per clock edge:
  - EMPTY, accept -> ONE; main loads input.
  - ONE, accept & drain -> ONE; main loads input (single-cycle throughput, latency 1).
  - ONE, accept & !drain -> FULL; skid loads input, main holds.
  - ONE, !accept & drain -> EMPTY.
  - FULL, drain -> ONE; main loads skid, skid invalidated. No accept is possible (in_ready=0).
  - FULL, !drain -> FULL; hold.
- Latency: accepted input appears on out_* the next cycle when the stage was EMPTY or draining. The skid path adds one cycle.
- Ordering: strictly FIFO. The skid entry always leaves before any newer input.
- Flush (synchronous, highest priority after reset):
  - next state EMPTY; main_valid=0, skid_valid=0, in_ready=1.
  - out_reg_write and out_output_sel forced to 0 (bubble: no writeback).
  - other payload fields hold their values.
  - an in_valid presented in the same cycle is discarded.
  - stall_count is not modified by flush.
- Invalid entries: whenever out_valid=0, out_reg_write=0 is guaranteed, so downstream may use it without qualification.
- stall_count increments by 1 on each edge where out_valid & !out_ready. It saturates at all-ones (2^CNT_W-1) with no wrap. It is cleared only by reset.
- Payload registers with a disabled load hold their value. No X propagation from an unaccepted input.

Test Plan:
- Reset mid-stream: load in_data1=0x5A, then pulse reset low asynchronously between edges -> out_valid=0, out_data1=0x00, in_ready=1 immediately, without waiting for clk.
- Streaming: out_ready=1; send 4 instructions (rd=1..4, data1=0x11,0x22,0x33,0x44) back-to-back -> each appears 1 cycle later in order; in_ready stays 1; stall_count=0.
- Backpressure/skid: out_ready=0; send A(data1=0xA1) then B(0xB2) -> FULL, in_ready=0 on the following cycle, stall_count counts; raise out_ready -> A then B delivered, in_ready returns to 1 with no loss or duplication.
- Flush while FULL with in_valid=1 (C, rd=7, reg_write=1) -> next cycle out_valid=0, out_reg_write=0, in_ready=1; C never appears.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_count reaches 15 and stays 15.
- Width generality with DATA_W=16, REG_ADDR_W=5: pass data2=0xBEEF, rd=31 -> out_data2=0xBEEF, out_rd=31 one cycle later.
